// File: rtl/spike_rate_decoder_pkg.sv
`default_nettype none
//============================================================================
// Module      : spike_dec_pkg
// Description : Shared types and constants for the spike rate decoder:
//               FSM state encoding, default configuration values and a
//               helper returning the saturation limit of a CNT_W counter.
// Revision    : 1.0 - initial release
//============================================================================
package spike_dec_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } spike_dec_state_e;

    localparam int c_def_window_log2 = 8;
    localparam int c_def_cnt_w       = 8;
    localparam int c_def_n_ch        = 2;

    // Largest value representable in cnt_w bits (2^cnt_w - 1).
    function automatic logic [31:0] sat_limit(input int cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spike_chan_counter.sv
`default_nettype none
//============================================================================
// Module      : spike_chan_counter
// Description : One decoder channel: spike-event detection, saturating
//               spike counter and per-window saturation flag.
//               Build option SPIKE_DEC_EDGE_EN: count rising edges of the
//               spike line instead of every high cycle.
// Ports       : clk, rst_n    - clock, async active-low reset
//               i_spike       - spike line of this channel
//               i_count_en    - window is running, events may be counted
//               i_clear       - zero counter and flag (idle / window end)
//               o_next_cnt    - count including this cycle's event
//               o_next_sat    - sat flag including this cycle's event
// Revision    : 1.0 - initial release
//============================================================================
module spike_chan_counter
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = c_def_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_spike,
    input  logic             i_count_en,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_next_cnt,
    output logic             o_next_sat
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(sat_limit(CNT_W));

    logic             w_event;
    logic             w_inc;
    logic             w_at_limit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

`ifdef SPIKE_DEC_EDGE_EN
    // History tracks the line in every state so a line already high when
    // counting starts does not produce an event.
    logic r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= i_spike;
        end
    end

    assign w_event = i_spike & ~r_hist;
`else
    assign w_event = i_spike;
`endif

    // The next values fold in the current cycle's event so the parent can
    // publish them on the terminal edge without losing the last spike.
    // The flag marks an event that arrived while the count was already at
    // its limit, i.e. a spike that could not be represented.
    always_comb begin
        w_inc      = i_count_en & w_event;
        w_at_limit = (r_cnt == c_limit);
        o_next_cnt = r_cnt;
        if (w_inc && !w_at_limit) begin
            o_next_cnt = r_cnt + CNT_W'(1);
        end
        o_next_sat = r_sat | (w_inc & w_at_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_count_en) begin
            r_cnt <= o_next_cnt;
            r_sat <= o_next_sat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
//============================================================================
// Module      : spike_rate_decoder
// Description : Decodes N_CH spike trains into per-channel firing rates by
//               counting events over 2^WINDOW_LOG2-cycle windows and
//               publishing the counts through a valid/ready register.
//               Build option SPIKE_DEC_EDGE_EN: rising-edge event detection.
// Ports       : clk, rst_n   - clock, async active-low reset
//               ena          - decode enable (low holds the block idle)
//               spike_in     - spike lines, bit i = channel i
//               rate         - published counts, ch i at [i*CNT_W +: CNT_W]
//               rate_valid   - rate holds an unconsumed result
//               rate_ready   - consumer accepts rate
//               sat          - per-channel saturation in published window
//               overrun      - sticky, unconsumed result was overwritten
// Revision    : 1.0 - initial release
//============================================================================
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int WINDOW_LOG2 = c_def_window_log2,
    parameter int CNT_W       = c_def_cnt_w,
    parameter int N_CH        = c_def_n_ch
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [N_CH-1:0]       spike_in,
    output logic [N_CH*CNT_W-1:0] rate,
    output logic                  rate_valid,
    input  logic                  rate_ready,
    output logic [N_CH-1:0]       sat,
    output logic                  overrun
);

    localparam logic [0:0]             c_st_idle  = IDLE;
    localparam logic [0:0]             c_st_count = COUNT;
    localparam logic [WINDOW_LOG2-1:0] c_win_last = '1;

    logic [0:0]             r_state;
    logic [WINDOW_LOG2-1:0] r_win;
    logic [N_CH*CNT_W-1:0]  r_rate;
    logic [N_CH-1:0]        r_sat;
    logic                   r_valid;
    logic                   r_overrun;

    logic                   w_active;
    logic                   w_terminal;
    logic                   w_publish;
    logic                   w_xfer;
    logic                   w_chan_clear;
    logic [N_CH*CNT_W-1:0]  w_next_rate;
    logic [N_CH-1:0]        w_next_sat;

    // A window only progresses while in COUNT with ena still high; dropping
    // ena aborts the partial window, including on its terminal cycle.
    assign w_active     = (r_state == c_st_count) & ena;
    assign w_terminal   = (r_win == c_win_last);
    assign w_publish    = w_active & w_terminal;
    assign w_xfer       = r_valid & rate_ready;
    assign w_chan_clear = ~w_active | w_terminal;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            spike_chan_counter #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_spike    (spike_in[gi]),
                .i_count_en (w_active),
                .i_clear    (w_chan_clear),
                .o_next_cnt (w_next_rate[gi*CNT_W +: CNT_W]),
                .o_next_sat (w_next_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:  if (ena)  r_state <= c_st_count;
                c_st_count: if (!ena) r_state <= c_st_idle;
                default:    r_state <= c_st_idle;
            endcase
        end
    end

    // Wraps from the terminal value straight to 0: back-to-back windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else if (w_active) begin
            r_win <= r_win + WINDOW_LOG2'(1);
        end else begin
            r_win <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate    <= '0;
            r_sat     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_publish) begin
            r_rate  <= w_next_rate;
            r_sat   <= w_next_sat;
            r_valid <= 1'b1;
            if (r_valid && !rate_ready) begin
                r_overrun <= 1'b1;
            end else if (w_xfer) begin
                r_overrun <= 1'b0;
            end
        end else if (w_xfer) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign rate       = r_rate;
    assign sat        = r_sat;
    assign rate_valid = r_valid;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire
